// File: rtl/decodificador_quadratura.sv
// Quadrature encoder front end: synchronizes and debounces both channels, decodes
// Gray-code direction and issues single-cycle step strobes for the up/down counter.
module decodificador_quadratura #(
  parameter int unsigned FILTRO_CICLOS = 4,
  parameter int unsigned PASSOS        = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enc_a,
  input  logic enc_b,
  input  logic habilitar,
  output logic acrescer,
  output logic decrecer,
  output logic erro
);

  localparam int unsigned CW     = 8;
  localparam int unsigned INIT_W = 9;
  localparam int unsigned AW     = 4;
  localparam logic signed [AW-1:0] PASSOS_POS = AW'(PASSOS);
  localparam logic signed [AW-1:0] PASSOS_NEG = -PASSOS_POS;

  typedef enum logic {INICIO, ATIVO} estado_t;

  estado_t              estado_q, estado_d;
  logic                 a_s1_q, a_s1_d, a_s2_q, a_s2_d;
  logic                 b_s1_q, b_s1_d, b_s2_q, b_s2_d;
  logic                 a_filt_q, a_filt_d, b_filt_q, b_filt_d;
  logic [CW-1:0]        cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [INIT_W-1:0]    ini_cnt_q, ini_cnt_d;
  logic [1:0]           prev_q, prev_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 acrescer_q, acrescer_d;
  logic                 decrecer_q, decrecer_d;
  logic                 erro_q, erro_d;

  logic signed [AW-1:0] delta;
  logic signed [AW-1:0] acc_sum;
  logic [1:0]           cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= INICIO;
      a_s1_q     <= 1'b0;
      a_s2_q     <= 1'b0;
      b_s1_q     <= 1'b0;
      b_s2_q     <= 1'b0;
      a_filt_q   <= 1'b0;
      b_filt_q   <= 1'b0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      ini_cnt_q  <= '0;
      prev_q     <= 2'b00;
      acc_q      <= '0;
      acrescer_q <= 1'b0;
      decrecer_q <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      a_s1_q     <= a_s1_d;
      a_s2_q     <= a_s2_d;
      b_s1_q     <= b_s1_d;
      b_s2_q     <= b_s2_d;
      a_filt_q   <= a_filt_d;
      b_filt_q   <= b_filt_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      ini_cnt_q  <= ini_cnt_d;
      prev_q     <= prev_d;
      acc_q      <= acc_d;
      acrescer_q <= acrescer_d;
      decrecer_q <= decrecer_d;
      erro_q     <= erro_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    a_s1_d     = enc_a;
    a_s2_d     = a_s1_q;
    b_s1_d     = enc_b;
    b_s2_d     = b_s1_q;
    a_filt_d   = a_filt_q;
    b_filt_d   = b_filt_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    ini_cnt_d  = ini_cnt_q;
    prev_d     = prev_q;
    acc_d      = acc_q;
    acrescer_d = 1'b0;
    decrecer_d = 1'b0;
    erro_d     = 1'b0;
    delta      = '0;
    acc_sum    = '0;
    cur        = {a_filt_q, b_filt_q};

    unique case (estado_q)
      // Bypass the filter and track the resting position so power-up never steps
      INICIO: begin
        a_filt_d = a_s2_q;
        b_filt_d = b_s2_q;
        cnt_a_d  = '0;
        cnt_b_d  = '0;
        prev_d   = {a_s2_q, b_s2_q};
        acc_d    = '0;
        if (ini_cnt_q == INIT_W'(FILTRO_CICLOS + 1)) begin
          estado_d = ATIVO;
        end else begin
          ini_cnt_d = ini_cnt_q + INIT_W'(1);
        end
      end

      ATIVO: begin
        if (a_s2_q == a_filt_q) begin
          cnt_a_d = '0;
        end else if (cnt_a_q == CW'(FILTRO_CICLOS - 1)) begin
          a_filt_d = a_s2_q;
          cnt_a_d  = '0;
        end else begin
          cnt_a_d = cnt_a_q + CW'(1);
        end

        if (b_s2_q == b_filt_q) begin
          cnt_b_d = '0;
        end else if (cnt_b_q == CW'(FILTRO_CICLOS - 1)) begin
          b_filt_d = b_s2_q;
          cnt_b_d  = '0;
        end else begin
          cnt_b_d = cnt_b_q + CW'(1);
        end

        prev_d = cur;
        case ({prev_q, cur})
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: delta = AW'(1);
          4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: delta = -AW'(1);
          4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: erro_d = 1'b1;
          default: delta = '0;
        endcase

        // Disabled: progress is discarded but the previous state keeps tracking
        acc_sum = acc_q + delta;
        if (!habilitar) begin
          acc_d = '0;
        end else if (delta != '0) begin
          if (acc_sum == PASSOS_POS) begin
            acrescer_d = 1'b1;
            acc_d      = '0;
          end else if (acc_sum == PASSOS_NEG) begin
            decrecer_d = 1'b1;
            acc_d      = '0;
          end else begin
            acc_d = acc_sum;
          end
        end
      end

      default: estado_d = INICIO;
    endcase
  end

  assign acrescer = acrescer_q;
  assign decrecer = decrecer_q;
  assign erro     = erro_q;

endmodule

// File: tb/tb_decodificador_quadratura.sv
// Scoreboard bench: two encoder decoders (PASSOS=1 and PASSOS=4) share one stimulus
// stream; each directed vector carries the hand-derived strobe expected from each.
module tb_decodificador_quadratura;

  localparam int unsigned F   = 4;
  localparam int unsigned LAT = F + 3;
  localparam logic [2:0] NO = 3'b000;
  localparam logic [2:0] UP = 3'b001;
  localparam logic [2:0] DN = 3'b010;
  localparam logic [2:0] ER = 3'b100;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  code;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enc_a = 1'b1;
  logic enc_b = 1'b1;
  logic habilitar = 1'b1;
  logic acr1, dec1, err1;
  logic acr4, dec4, err4;

  int unsigned cyc = 0;
  int n_vec = 0;
  int n_fail = 0;
  ev_t q0[$];
  ev_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decodificador_quadratura #(.FILTRO_CICLOS(F), .PASSOS(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .habilitar(habilitar),
    .acrescer(acr1), .decrecer(dec1), .erro(err1)
  );

  decodificador_quadratura #(.FILTRO_CICLOS(F), .PASSOS(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .habilitar(habilitar),
    .acrescer(acr4), .decrecer(dec4), .erro(err4)
  );

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpop(input int id, output ev_t e);
    if (id == 0) e = q0.pop_front();
    else         e = q1.pop_front();
  endtask

  task automatic mon(input int id, input logic [2:0] got);
    ev_t e;
    // anything strictly overdue was never produced
    while (qsize(id) > 0 && ((id == 0) ? q0[0].cyc : q1[0].cyc) < cyc) begin
      qpop(id, e);
      n_vec++; n_fail++;
      $display("FAIL missed_strobe inst%0d: got none, required code %b at cycle %0d (now %0d)",
               id, e.code, e.cyc, cyc);
    end
    if (got != NO) begin
      n_vec++;
      if (qsize(id) == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe inst%0d: got code %b at cycle %0d, required none",
                 id, got, cyc);
      end else begin
        qpop(id, e);
        if (e.cyc != cyc || e.code != got) begin
          n_fail++;
          $display("FAIL strobe inst%0d: got code %b at cycle %0d, required code %b at cycle %0d",
                   id, got, cyc, e.code, e.cyc);
        end
      end
    end else if (qsize(id) > 0 && ((id == 0) ? q0[0].cyc : q1[0].cyc) == cyc) begin
      qpop(id, e);
      n_vec++; n_fail++;
      $display("FAIL missed_strobe inst%0d: got none, required code %b at cycle %0d",
               id, e.code, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    mon(0, {err1, dec1, acr1});
    mon(1, {err4, dec4, acr4});
  end

  task automatic check(input string name, input logic got, input logic req);
    n_vec++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  // Drive one encoder level at the current negedge and hold it; e1/e4 are the
  // strobes expected F+3 cycles later from the PASSOS=1 and PASSOS=4 instances.
  task automatic vec(input logic a, input logic b, input logic en, input int hold,
                     input logic [2:0] e1, input logic [2:0] e4);
    enc_a = a;
    enc_b = b;
    habilitar = en;
    if (e1 != NO) q0.push_back('{cyc: cyc + LAT, code: e1});
    if (e4 != NO) q1.push_back('{cyc: cyc + LAT, code: e4});
    repeat (hold) @(negedge clk);
  endtask

  initial begin
    // Reset with the encoder resting at 11
    repeat (3) @(negedge clk);
    check("rst_acr_p1", acr1, 1'b0);
    check("rst_dec_p1", dec1, 1'b0);
    check("rst_err_p1", err1, 1'b0);
    check("rst_acr_p4", acr4, 1'b0);
    check("rst_dec_p4", dec4, 1'b0);
    check("rst_err_p4", err4, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Forward from 11 round to 00; PASSOS=4 fires on the 4th step
    vec(0, 1, 1, 10, UP, NO);
    vec(0, 0, 1, 10, UP, NO);
    vec(1, 0, 1, 10, UP, NO);
    vec(1, 1, 1, 10, UP, UP);
    vec(0, 1, 1, 10, UP, NO);
    vec(0, 0, 1, 10, UP, NO);
    // Glitch of 3 cycles rejected, 4 cycles accepted
    vec(1, 0, 1, 3,  NO, NO);
    vec(0, 0, 1, 10, NO, NO);
    vec(1, 0, 1, 4,  UP, NO);
    vec(0, 0, 1, 10, DN, NO);
    // Two backward returns to 11 and empties the PASSOS=4 accumulator
    vec(0, 1, 1, 10, DN, NO);
    vec(1, 1, 1, 10, DN, NO);
    // Two forward then two backward: no detent crossed
    vec(0, 1, 1, 10, UP, NO);
    vec(0, 0, 1, 10, UP, NO);
    vec(0, 1, 1, 10, DN, NO);
    vec(1, 1, 1, 10, DN, NO);
    // Eight forward steps: two detents
    vec(0, 1, 1, 10, UP, NO);
    vec(0, 0, 1, 10, UP, NO);
    vec(1, 0, 1, 10, UP, NO);
    vec(1, 1, 1, 10, UP, UP);
    vec(0, 1, 1, 10, UP, NO);
    vec(0, 0, 1, 10, UP, NO);
    vec(1, 0, 1, 10, UP, NO);
    vec(1, 1, 1, 10, UP, UP);
    // Both channels change together
    vec(0, 0, 1, 10, ER, ER);
    // Three forward steps while disabled, then re-enable
    vec(1, 0, 0, 10, NO, NO);
    vec(1, 1, 0, 10, NO, NO);
    vec(0, 1, 0, 10, NO, NO);
    vec(0, 1, 1, 10, NO, NO);
    vec(0, 0, 1, 10, UP, NO);

    // Reset asserted right as an acrescer pulse is registered
    vec(1, 0, 1, 0, NO, NO);
    repeat (LAT) @(posedge clk);
    #1;
    check("pulse_before_reset", acr1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("acr_p1_in_reset", acr1, 1'b0);
    check("dec_p1_in_reset", dec1, 1'b0);
    check("err_p1_in_reset", err1, 1'b0);
    check("acr_p4_in_reset", acr4, 1'b0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    vec(1, 1, 1, 12, UP, NO);

    while (q0.size() > 0) begin
      n_vec++; n_fail++;
      $display("FAIL leftover inst0: got none, required code %b at cycle %0d", q0[0].code, q0[0].cyc);
      void'(q0.pop_front());
    end
    while (q1.size() > 0) begin
      n_vec++; n_fail++;
      $display("FAIL leftover inst1: got none, required code %b at cycle %0d", q1[0].code, q1[0].cyc);
      void'(q1.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
